// File: rtl/pong_game_ctrl.sv
// Game-flow controller for the VGA pong design: state machine, serve/over
// delay timer, BCD scores, remaining-ball count, pause and win detection.
module pong_game_ctrl #(
  parameter int NUM_BALLS    = 3,
  parameter int BALL_W       = 4,
  parameter int DIGITS       = 2,
  parameter int WIN_SCORE    = 9,
  parameter int DELAY_FRAMES = 120,
  parameter int TMR_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [3:0]          btn,
  input  logic                pause_btn,
  input  logic                l_hit,
  input  logic                r_hit,
  input  logic                l_mis,
  input  logic                r_mis,
  output logic                gra_still,
  output logic [2:0]          state,
  output logic [BALL_W-1:0]   balls_left,
  output logic [4*DIGITS-1:0] l_score,
  output logic [4*DIGITS-1:0] r_score,
  output logic                serve_dir,
  output logic [1:0]          winner,
  output logic                timer_up
);
  typedef enum logic [2:0] {
    NEWGAME = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, OVER = 3'd4
  } state_t;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int val);
    logic [4*DIGITS-1:0] r;
    int v;
    r = '0;
    v = val;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Ripple +1 across BCD digits; an all-9s score keeps its value.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
        else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return c ? v : r;
  endfunction

  localparam logic [4*DIGITS-1:0] WIN_BCD = to_bcd(WIN_SCORE);
  localparam bit                  WIN_EN  = (WIN_SCORE != 0);

  state_t              st, st_nxt;
  logic [TMR_W-1:0]    timer;
  logic                pause_q;
  logic                pause_rise;
  logic [4*DIGITS-1:0] l_next, r_next;
  logic                l_win, r_win;
  logic                any_mis;

  assign pause_rise = pause_btn & ~pause_q;
  assign l_next     = bcd_inc(l_score);
  assign r_next     = bcd_inc(r_score);
  assign l_win      = WIN_EN && (l_next == WIN_BCD);
  assign r_win      = WIN_EN && (r_next == WIN_BCD);
  assign any_mis    = l_mis | r_mis;
  assign state      = st;
  assign timer_up   = (timer == '0);

  always_ff @(posedge clk) begin
    if (reset) st <= NEWGAME;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      NEWGAME: if (btn != 4'd0) st_nxt = PLAY;
      PLAY: begin
        if (l_hit)        begin if (l_win) st_nxt = OVER; end
        else if (r_hit)   begin if (r_win) st_nxt = OVER; end
        else if (any_mis) st_nxt = (balls_left == '0) ? OVER : SERVE;
        else if (pause_rise) st_nxt = PAUSE;
      end
      PAUSE:   if (pause_rise) st_nxt = PLAY;
      SERVE:   if (timer_up && btn != 4'd0) st_nxt = PLAY;
      OVER:    if (timer_up) st_nxt = NEWGAME;
      default: st_nxt = NEWGAME;
    endcase
  end

  always_comb begin
    gra_still = (st != PLAY);
  end

  // Datapath; entering NEWGAME (from OVER or an illegal code) clears the game.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_q    <= 1'b1;
      timer      <= '0;
      balls_left <= BALL_W'(NUM_BALLS - 1);
      l_score    <= '0;
      r_score    <= '0;
      serve_dir  <= 1'b0;
      winner     <= 2'b00;
    end else begin
      pause_q <= pause_btn;
      if (st_nxt != st && (st_nxt == SERVE || st_nxt == OVER))
        timer <= TMR_W'(DELAY_FRAMES);
      else if (frame_tick && timer != '0)
        timer <= timer - 1'b1;

      if (st_nxt == NEWGAME) begin
        balls_left <= BALL_W'(NUM_BALLS - 1);
        l_score    <= '0;
        r_score    <= '0;
        winner     <= 2'b00;
      end else if (st == PLAY) begin
        if (l_hit) begin
          l_score <= l_next;
          if (l_win) winner <= 2'b01;
        end else if (r_hit) begin
          r_score <= r_next;
          if (r_win) winner <= 2'b10;
        end else if (any_mis) begin
          serve_dir <= ~l_mis;
          if (balls_left == '0)
            winner <= (l_score > r_score) ? 2'b01 :
                      (r_score > l_score) ? 2'b10 : 2'b11;
          else
            balls_left <= balls_left - 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Parametrised game-flow controller for the VGA ping-pong design. It is the next-generation successor of the top-level newgame/play/newball/over FSMD.
- Owns the game state machine, the serve-delay timer, the per-side BCD scores, the remaining-ball count, pause mode and win detection.
- Sits between the graphics engine (hit/miss pulses in, gra_still out) and the text renderer (score digits, ball count, state, winner).

Parameters:
- NUM_BALLS, 3: balls per game, including the first served ball; range 1..15.
- BALL_W, 4: width of balls_left; must hold NUM_BALLS-1.
- DIGITS, 2: BCD digits per side score.
- WIN_SCORE, 9: points that end the game immediately; 0 disables; must be below 10^DIGITS.
- DELAY_FRAMES, 120: frame ticks spent in SERVE and OVER before they can exit; must be 1 or more.
- TMR_W, 8: timer width; must hold DELAY_FRAMES.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame (x==0 && y==0)
- btn  in  4  paddle buttons, level; any nonzero value = "press"
- pause_btn  in  1  pause toggle, level; the block edge-detects it internally
- l_hit  in  1  one-cycle pulse: left paddle returned the ball
- r_hit  in  1  one-cycle pulse: right paddle returned the ball
- l_mis  in  1  one-cycle pulse: ball passed the left paddle
- r_mis  in  1  one-cycle pulse: ball passed the right paddle
- gra_still  out  1  freeze the graphics engine
- state  out  3  000 NEWGAME, 001 SERVE, 010 PLAY, 011 PAUSE, 100 OVER
- balls_left  out  BALL_W  balls remaining after the one in play
- l_score  out  4*DIGITS  left score, packed BCD, digit 0 in LSBs
- r_score  out  4*DIGITS  right score, packed BCD
- serve_dir  out  1  side that receives the next serve (0 left, 1 right)
- winner  out  2  00 none, 01 left, 10 right, 11 tie
- timer_up  out  1  serve/over delay has expired

Behaviour:
- Reset: every register updates on the clk rising edge only. On reset: state=NEWGAME, balls_left=NUM_BALLS-1, scores=0, serve_dir=0, winner=00, timer=0, pause edge register=1 (a button held through reset does not trigger). Reset mid-game aborts immediately; there is no partial state.
- Outputs: all outputs are registered, except gra_still and timer_up, which are combinational from registered state. gra_still=0 only in PLAY.
- Timer: loads DELAY_FRAMES on every transition into SERVE or OVER. Each frame_tick decrements it while it is nonzero. timer_up = (timer==0). A frame_tick arriving in the load cycle is ignored.
- NEWGAME: holds scores=0, balls_left=NUM_BALLS-1, winner=00. When btn!=0, go to PLAY on the next edge.
- PLAY, one event per cycle, priority l_hit > r_hit > (l_mis | r_mis):
  - hit: increment that side's score (BCD, per-digit 9->0 carry; saturate at all-9s).
  - If WIN_SCORE!=0 and the post-increment score == WIN_SCORE: winner=that side, go to OVER.
  - miss: serve_dir = missing side (l_mis wins if both). If balls_left==0, go to OVER with winner decided by comparing scores (equal -> 11). Otherwise decrement balls_left and go to SERVE.
  - Rising edge of pause_btn with no event in the same cycle: go to PAUSE.
- PAUSE: scores and balls frozen. hit/miss pulses are ignored. A rising edge of pause_btn returns to PLAY.
- SERVE: pause_btn ignored. When timer_up && btn!=0, go to PLAY.
- OVER: winner holds its value. When timer_up, go to NEWGAME; NEWGAME clears winner.
- pause_btn edges outside PLAY/PAUSE are consumed: the edge register still updates and no toggle is queued.
- Latency: an event pulse is reflected in the outputs one clk later.

Test Plan:
- Reset, then btn=0001 for one cycle -> state 000->010; balls_left=2; l_score=r_score=0x00.
- In PLAY, 3 l_hit pulses and 12 r_hit pulses -> l_score=0x03, r_score=0x12. Repeat with WIN_SCORE=9: the 9th l_hit gives winner=01 and state=100.
- l_mis with balls_left=2 -> state=001, balls_left=1, serve_dir=0. btn pressed before the 120th frame_tick -> stays 001. btn at or after timer_up -> 010.
- l_hit and r_mis in the same cycle -> only l_score increments; state stays 010.
- With balls_left=0 and scores 0x04/0x04, r_mis -> state=100, winner=11. After 120 frame_ticks -> state=000, winner=00.
- pause_btn pulse in PLAY -> 011 with gra_still=1; l_hit during PAUSE -> no change. A second pause_btn pulse -> 010. Assert reset during PAUSE -> all reset values.
